bbj_dot_acc_thresh: RTL and testbench

//  Streaming dot-product stage for the BNN compute path. Accepts (a, b, last) beats.

---
 rtl/bbj_acc_pkg.sv | 33 +++
 rtl/BlackBoxJam_mul_32s_11ns_32_2_1.sv | 26 ++
 rtl/bbj_dot_acc_thresh.sv | 109 ++++++++++
 tb/tb_bbj_dot_acc_thresh.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bbj_acc_pkg.sv
// Shared widths, saturation limits and stage control type for the dot-product
// accumulate/threshold stage.
package bbj_acc_pkg;

  localparam int A_W   = 32;
  localparam int B_W   = 11;
  localparam int P_W   = 32;
  localparam int ACC_W = 32;
  localparam int CNT_W = 16;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_MAX = '1;

  typedef struct packed {
    logic v;
    logic last;
    logic first;
  } stage_ctl_t;

  // One guard bit: the top two sum bits disagree exactly on overflow.
  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0] x,
    input logic signed [P_W-1:0]   p
  );
    logic signed [ACC_W:0] s;
    s = {x[ACC_W-1], x} + {{(ACC_W+1-P_W){p[P_W-1]}}, p};
    if (s[ACC_W:ACC_W-1] == 2'b01)      return ACC_MAX;
    else if (s[ACC_W:ACC_W-1] == 2'b10) return ACC_MIN;
    else                                return s[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/BlackBoxJam_mul_32s_11ns_32_2_1.sv
// Registered signed x unsigned multiplier; output truncated to DOUT_WIDTH bits.
module BlackBoxJam_mul_32s_11ns_32_2_1 #(
  parameter int DIN0_WIDTH = 32,
  parameter int DIN1_WIDTH = 11,
  parameter int DOUT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic [DOUT_WIDTH-1:0] dout
);

  // Only the low DOUT_WIDTH product bits are kept, so multiplying the
  // sign-/zero-extended operands at that width gives the wrapped result directly.
  logic [DOUT_WIDTH-1:0] ea;
  logic [DOUT_WIDTH-1:0] eb;

  assign ea = DOUT_WIDTH'($signed(din0));
  assign eb = DOUT_WIDTH'(din1);

  always_ff @(posedge clk) begin
    if (ce) dout <= ea * eb;
  end

endmodule

// File: rtl/bbj_dot_acc_thresh.sv
// Streaming dot product: multiply (a, b) beats, saturating-accumulate to `last`,
// then emit sum, beat count and the binarised activation (acc >= thresh).
module bbj_dot_acc_thresh
  import bbj_acc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [A_W-1:0]   s_a,
  input  logic [B_W-1:0]   s_b,
  input  logic             s_last,
  input  logic [ACC_W-1:0] thresh,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [ACC_W-1:0] m_acc,
  output logic [CNT_W-1:0] m_cnt,
  output logic             m_bit
);

  // Handshakes: a beat/result transfers on a rising edge where valid && ready.
  // The whole pipeline advances together; it stalls only while a result waits.
  logic adv;
  logic accept;

  stage_ctl_t ctl0;
  stage_ctl_t ctl1;
  logic       first;

  logic [A_W-1:0]          a0;
  logic [B_W-1:0]          b0;
  logic signed [ACC_W-1:0] thr0;
  logic signed [ACC_W-1:0] thr1;
  logic [P_W-1:0]          prod;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_next;

  assign adv     = !(m_valid && !m_ready);
  assign s_ready = adv && !reset;
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctl0  <= '0;
      ctl1  <= '0;
      first <= 1'b1;
    end else if (adv) begin
      ctl0 <= '{v: accept, last: s_last, first: first};
      ctl1 <= ctl0;
      if (accept) first <= s_last;
    end
  end

  // Data path carries no reset; the control valids qualify it.
  always_ff @(posedge clk) begin
    if (accept) begin
      a0 <= s_a;
      b0 <= s_b;
      if (first) thr0 <= thresh;
    end
    if (adv) thr1 <= thr0;
  end

  BlackBoxJam_mul_32s_11ns_32_2_1 #(
    .DIN0_WIDTH(A_W),
    .DIN1_WIDTH(B_W),
    .DOUT_WIDTH(P_W)
  ) u_mul (
    .clk (clk),
    .ce  (adv),
    .din0(a0),
    .din1(b0),
    .dout(prod)
  );

  always_comb begin
    acc_next = sat_add(ctl1.first ? '0 : acc, prod);
    cnt_next = ctl1.first ? CNT_W'(1) : ((cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      cnt     <= '0;
      m_valid <= 1'b0;
      m_acc   <= '0;
      m_cnt   <= '0;
      m_bit   <= 1'b0;
    end else begin
      if (adv && ctl1.v) begin
        acc <= acc_next;
        cnt <= cnt_next;
      end
      // A new load wins over a same-cycle drain.
      if (adv && ctl1.v && ctl1.last) begin
        m_valid <= 1'b1;
        m_acc   <= acc_next;
        m_cnt   <= cnt_next;
        m_bit   <= (acc_next >= thr1);
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bbj_dot_acc_thresh.sv
// Bench for bbj_dot_acc_thresh: driver tasks feed beats into a reference model
// that queues expected results; a monitor pops and compares on each output transfer.
module tb_bbj_dot_acc_thresh;
  import bbj_acc_pkg::*;

  localparam int W = ACC_W + CNT_W + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [A_W-1:0]   s_a = '0;
  logic [B_W-1:0]   s_b = '0;
  logic             s_last = 1'b0;
  logic [ACC_W-1:0] thresh = '0;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [ACC_W-1:0] m_acc;
  logic [CNT_W-1:0] m_cnt;
  logic             m_bit;

  bbj_dot_acc_thresh dut (
    .clk    (clk),
    .reset  (reset),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_a    (s_a),
    .s_b    (s_b),
    .s_last (s_last),
    .thresh (thresh),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_acc  (m_acc),
    .m_cnt  (m_cnt),
    .m_bit  (m_bit)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic hold = 1'b0;
  logic rand_rdy = 1'b0;
  always @(negedge clk)
    m_ready = hold ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, finish required earlier");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0]            exp_q[$];
  logic signed [ACC_W-1:0] md_acc = '0;
  logic [CNT_W-1:0]        md_cnt = '0;
  logic                    md_first = 1'b1;
  logic signed [ACC_W-1:0] md_thr = '0;

  task automatic model_beat(input logic signed [31:0] a, input logic [10:0] b,
                            input logic last, input logic signed [31:0] thr);
    longint p;
    longint s;
    logic signed [31:0] pt;
    if (md_first) begin
      md_thr = thr;
      md_acc = '0;
      md_cnt = '0;
    end
    p  = longint'(a) * longint'(b);
    pt = p[31:0];
    s  = longint'(md_acc) + longint'(pt);
    if (s > 64'sd2147483647)       s = 64'sd2147483647;
    else if (s < -64'sd2147483648) s = -64'sd2147483648;
    md_acc   = s[31:0];
    md_cnt   = (md_cnt == 16'hFFFF) ? md_cnt : md_cnt + 16'd1;
    md_first = last;
    if (last) exp_q.push_back({md_acc, md_cnt, (md_acc >= md_thr)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [31:0] a, input logic [10:0] b,
                           input logic last, input logic [31:0] thr);
    int  t;
    bit  done;
    t = 0;
    done = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_a = a;
    s_b = b;
    s_last = last;
    thresh = thr;
    while (!done) begin
      #1;
      if (s_ready) begin
        @(posedge clk);
        model_beat(a, b, last, thr);
        done = 1;
      end else begin
        t++;
        if (t > 200) begin
          check_eq("accept_timeout", 64'(s_ready), 1);
          done = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain", 64'(exp_q.size()), 0);
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] e;
  int last_pop = 0;
  int prev_pop = 0;

  always begin
    @(negedge clk);
    #1;
    if (!reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("result_queue", 64'(m_valid), 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("m_acc", 64'(m_acc), 64'(e[W-1:CNT_W+1]));
        check_eq("m_cnt", 64'(m_cnt), 64'(e[CNT_W:1]));
        check_eq("m_bit", 64'(m_bit), 64'(e[0]));
        prev_pop = last_pop;
        last_pop = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int len;
    logic [31:0] ra;
    logic [31:0] rt;

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_m_valid", 64'(m_valid), 0);
    check_eq("rst_m_acc", 64'(m_acc), 0);
    check_eq("rst_m_cnt", 64'(m_cnt), 0);
    check_eq("rst_m_bit", 64'(m_bit), 0);
    check_eq("rst_s_ready", 64'(s_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("s_ready_after_rst", 64'(s_ready), 1);

    // basic vector and latency
    send_beat(32'd3, 11'd4, 1'b0, 32'd0);
    send_beat(-32'sd2, 11'd7, 1'b0, 32'd0);
    send_beat(32'd5, 11'd1, 1'b1, 32'd0);
    idle();
    #1;
    check_eq("lat_e0", 64'(m_valid), 0);
    @(negedge clk);
    #1;
    check_eq("lat_e1", 64'(m_valid), 0);
    @(negedge clk);
    #1;
    check_eq("lat_e2", 64'(m_valid), 1);
    check_eq("basic_acc", 64'(m_acc), 64'd3);
    drain();

    // back-to-back single-beat vectors
    send_beat(32'd1, 11'd1, 1'b1, 32'd1);
    send_beat(-32'sd5, 11'd2, 1'b1, -32'sd9);
    idle();
    drain();
    check_eq("b2b_gap", 64'(last_pop - prev_pop), 1);

    // backpressure: result held while the next vector waits
    hold = 1'b1;
    send_beat(32'd7, 11'd1, 1'b1, 32'd0);
    fork
      begin
        send_beat(32'd3, 11'd4, 1'b0, 32'd5);
        send_beat(-32'sd2, 11'd7, 1'b0, -32'sd100);
        send_beat(32'd5, 11'd1, 1'b1, -32'sd100);
        idle();
      end
      begin
        int t;
        t = 0;
        while (!m_valid && t < 20) begin
          @(negedge clk);
          #1;
          t++;
        end
        check_eq("hold_seen", 64'(m_valid), 1);
        repeat (5) begin
          @(negedge clk);
          #1;
          check_eq("hold_s_ready", 64'(s_ready), 0);
          check_eq("hold_m_acc", 64'(m_acc), 64'd7);
        end
        hold = 1'b0;
      end
    join
    drain();

    // saturation both ways
    for (int i = 0; i < 3; i++) send_beat(32'h3FFF_FFFF, 11'd1, (i == 2), 32'd0);
    for (int i = 0; i < 3; i++) send_beat(32'hC000_0000, 11'd1, (i == 2), 32'd0);
    idle();
    drain();

    // product wrap
    send_beat(32'h0020_0000, 11'h400, 1'b1, 32'd0);
    idle();
    drain();

    // reset mid-vector
    send_beat(32'd10, 11'd1, 1'b0, 32'd0);
    send_beat(32'd20, 11'd1, 1'b0, 32'd0);
    @(negedge clk);
    s_valid = 1'b0;
    reset = 1'b1;
    md_first = 1'b1;
    #1;
    check_eq("rst_mid_valid", 64'(m_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("post_rst_valid", 64'(m_valid), 0);
    send_beat(32'd2, 11'd3, 1'b1, 32'd0);
    idle();
    drain();

    // random vectors with bubbles and random downstream ready
    rand_rdy = 1'b1;
    for (int v = 0; v < 8; v++) begin
      len = $urandom_range(1, 5);
      rt = 32'($urandom_range(0, 4000)) - 32'd2000;
      for (int k = 0; k < len; k++) begin
        ra = 32'($urandom_range(0, 2000)) - 32'd1000;
        send_beat(ra, 11'($urandom_range(0, 2047)), (k == len - 1), rt);
        if ($urandom_range(0, 3) == 0) idle();
      end
    end
    idle();
    drain();
    rand_rdy = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
